// File: rtl/uart_rx_oversample.sv
// 8N1 UART receiver: two-flop input synchroniser, 16x oversampling with a 3-sample
// majority vote per bit, glitch rejection on the start bit and framing-error reporting.
module uart_rx_oversample #(
   parameter int unsigned CLK_HZ     = 50000000,
   parameter int unsigned BAUD       = 115200,
   parameter int unsigned OVERSAMPLE = 16,
   parameter int unsigned DIV        = CLK_HZ / (BAUD * OVERSAMPLE)
) (
   input  logic       i_Clk,
   input  logic       i_Rst,
   input  logic       i_Rx,
   output logic [7:0] o_Data,
   output logic       o_fDone,
   output logic       o_fErr,
   output logic       o_fBusy
);

   localparam int unsigned TICK_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int unsigned SAMP_W = 4;
   localparam int unsigned BIT_W  = 3;

   localparam logic [SAMP_W-1:0] SAMP_V0   = SAMP_W'(7);
   localparam logic [SAMP_W-1:0] SAMP_V1   = SAMP_W'(8);
   localparam logic [SAMP_W-1:0] SAMP_V2   = SAMP_W'(9);
   localparam logic [SAMP_W-1:0] SAMP_LAST = SAMP_W'(15);
   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(7);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_BREAK
   } state_t;

   state_t            state_q, state_d;
   logic              rx_meta_q, rx_s_q;
   logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
   logic [SAMP_W-1:0] samp_q, samp_d;
   logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic [2:0]        vote_q, vote_d;
   logic [7:0]        shift_q, shift_d;
   logic [7:0]        data_q, data_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic              busy_q, busy_d;

   logic              tick_c;
   logic              bit_end_c;
   logic              vote_bit_c;

   // Sample timing, vote capture and frame sequencing.
   always_comb begin
      tick_c     = (tick_cnt_q == TICK_W'(DIV - 1));
      bit_end_c  = tick_c && (samp_q == SAMP_LAST);
      tick_cnt_d = tick_c ? '0 : tick_cnt_q + 1'b1;
      samp_d     = tick_c ? samp_q + 1'b1 : samp_q;

      vote_d = vote_q;
      if (tick_c) begin
         if (samp_q == SAMP_V0) vote_d[0] = rx_s_q;
         if (samp_q == SAMP_V1) vote_d[1] = rx_s_q;
         if (samp_q == SAMP_V2) vote_d[2] = rx_s_q;
      end
      // vote_d already holds the sample-9 capture on the stop-bit decision tick
      vote_bit_c = (vote_d[0] & vote_d[1]) | (vote_d[0] & vote_d[2]) | (vote_d[1] & vote_d[2]);

      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      data_d    = data_q;
      done_d    = 1'b0;
      err_d     = 1'b0;

      case (state_q)
         S_IDLE: begin
            tick_cnt_d = '0;
            samp_d     = '0;
            bit_cnt_d  = '0;
            if (!rx_s_q) state_d = S_START;
         end
         S_START: begin
            if (bit_end_c) state_d = vote_bit_c ? S_IDLE : S_DATA;
         end
         S_DATA: begin
            if (bit_end_c) begin
               shift_d   = {vote_bit_c, shift_q[7:1]};
               bit_cnt_d = bit_cnt_q + 1'b1;
               if (bit_cnt_q == BIT_LAST) state_d = S_STOP;
            end
         end
         S_STOP: begin
            // Decide mid stop bit so a following start edge is never missed.
            if (tick_c && (samp_q == SAMP_V2)) begin
               if (vote_bit_c) begin
                  data_d  = shift_q;
                  done_d  = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  err_d   = 1'b1;
                  state_d = S_BREAK;
               end
            end
         end
         S_BREAK: begin
            if (rx_s_q) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         state_q    <= S_IDLE;
         rx_meta_q  <= 1'b1;
         rx_s_q     <= 1'b1;
         tick_cnt_q <= '0;
         samp_q     <= '0;
         bit_cnt_q  <= '0;
         vote_q     <= '0;
         shift_q    <= '0;
         data_q     <= '0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         rx_meta_q  <= i_Rx;
         rx_s_q     <= rx_meta_q;
         tick_cnt_q <= tick_cnt_d;
         samp_q     <= samp_d;
         bit_cnt_q  <= bit_cnt_d;
         vote_q     <= vote_d;
         shift_q    <= shift_d;
         data_q     <= data_d;
         done_q     <= done_d;
         err_q      <= err_d;
         busy_q     <= busy_d;
      end
   end

   assign o_Data  = data_q;
   assign o_fDone = done_q;
   assign o_fErr  = err_q;
   assign o_fBusy = busy_q;

endmodule

// File: tb/tb_uart_rx_oversample.sv
// Scoreboard bench for uart_rx_oversample: frames are generated as serial waveforms,
// the expected strobe for each is queued, and a monitor checks every strobe in order.
module tb_uart_rx_oversample;

   localparam int unsigned DIV      = 4;
   localparam int          BIT_CLKS = 16 * DIV;

   typedef struct packed {
      logic       err;
      logic [7:0] data;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx  = 1'b1;
   logic [7:0] o_Data;
   logic       o_fDone;
   logic       o_fErr;
   logic       o_fBusy;

   exp_t       exp_q[$];
   exp_t       mon_e;
   logic [7:0] last_good = 8'h00;
   int         tests = 0;
   int         fails = 0;
   int         cyc = 0;
   int         last_done_cyc = 0;
   int         n_done = 0;
   int         n_err = 0;
   logic       prev_done = 1'b0;
   logic       prev_err = 1'b0;

   uart_rx_oversample #(.DIV(DIV)) dut (
      .i_Clk  (clk),
      .i_Rst  (rst),
      .i_Rx   (rx),
      .o_Data (o_Data),
      .o_fDone(o_fDone),
      .o_fErr (o_fErr),
      .o_fBusy(o_fBusy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: every strobe must match the head of the expectation queue.
   always @(negedge clk) begin
      if (o_fDone && o_fErr) begin
         tests++; fails++;
         $display("FAIL both_strobes: done=%b err=%b, required never both high", o_fDone, o_fErr);
      end
      if (o_fDone || o_fErr) begin
         tests++;
         if ((o_fDone && prev_done) || (o_fErr && prev_err)) begin
            fails++;
            $display("FAIL strobe_width: strobe high two cycles in a row at cycle %0d", cyc);
         end else if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_strobe: done=%b err=%b data=%h, required none", o_fDone, o_fErr, o_Data);
         end else begin
            mon_e = exp_q.pop_front();
            if (mon_e.err !== o_fErr || mon_e.data !== o_Data || o_fBusy !== o_fErr) begin
               fails++;
               $display("FAIL strobe: got err=%b data=%h busy=%b, required err=%b data=%h busy=%b",
                        o_fErr, o_Data, o_fBusy, mon_e.err, mon_e.data, mon_e.err);
            end
         end
         if (o_fDone) begin n_done++; last_done_cyc = cyc; end
         if (o_fErr) n_err++;
      end
      prev_done = o_fDone;
      prev_err  = o_fErr;
   end

   task automatic check(input string name, input int got, input int exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, required %0h", name, got, exp);
      end
   endtask

   // Drives one 10-bit frame starting at the current negedge; optional one-clock low spike.
   task automatic send_frame(input logic [7:0] b, input logic stop, input int bit_clks,
                             input int spike_at, input logic push);
      logic [9:0] bits;
      exp_t       e;
      bits = {stop, b, 1'b0};
      if (push) begin
         if (stop) begin
            e.err = 1'b0; e.data = b; last_good = b;
         end else begin
            e.err = 1'b1; e.data = last_good;
         end
         exp_q.push_back(e);
      end
      for (int c = 0; c < 10 * bit_clks; c++) begin
         rx = (c == spike_at) ? 1'b0 : bits[4'(c / bit_clks)];
         @(negedge clk);
      end
   endtask

   task automatic drain(input int max_clks);
      int n = 0;
      while (exp_q.size() != 0 && n < max_clks) begin
         @(negedge clk);
         n++;
      end
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL drain: %0d expected strobes missing, required 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      last_good = 8'h00;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] des_seq[9];
      int t0, d0, e0;
      des_seq = '{8'h02, 8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};

      repeat (3) @(negedge clk);
      rst = 1'b0;
      check("reset_data", int'(o_Data), 0);
      check("reset_flags", int'({o_fDone, o_fErr, o_fBusy}), 0);

      // Single frame, with end-to-end latency from the falling i_Rx edge.
      t0 = cyc;
      send_frame(8'hA5, 1'b1, BIT_CLKS, -1, 1'b1);
      drain(200);
      check("single_done_count", n_done, 1);
      check("single_err_count", n_err, 0);
      tests++;
      if ((last_done_cyc - t0) < 618 || (last_done_cyc - t0) > 620) begin
         fails++;
         $display("FAIL latency: got %0d clocks, required 619 +/- 1", last_done_cyc - t0);
      end
      check("single_busy_after", int'(o_fBusy), 0);

      // Back-to-back command/key stream.
      d0 = n_done;
      foreach (des_seq[i]) send_frame(des_seq[i], 1'b1, BIT_CLKS, -1, 1'b1);
      drain(200);
      check("b2b_done_count", n_done - d0, 9);
      check("b2b_err_count", n_err, 0);

      // Short glitch is rejected after one bit period.
      d0 = n_done;
      rx = 1'b0;
      repeat (20) @(negedge clk);
      rx = 1'b1;
      repeat (10) @(negedge clk);
      check("glitch_busy_during", int'(o_fBusy), 1);
      repeat (44) @(negedge clk);
      check("glitch_busy_after", int'(o_fBusy), 0);
      repeat (64) @(negedge clk);
      check("glitch_no_strobe", (n_done - d0) + n_err, 0);

      // Framing error with a held-low line, then recovery.
      pulse_reset();
      check("reset2_data", int'(o_Data), 0);
      e0 = n_err;
      send_frame(8'h3C, 1'b0, BIT_CLKS, -1, 1'b1);
      repeat (200) @(negedge clk);
      check("break_busy_low_line", int'(o_fBusy), 1);
      rx = 1'b1;
      repeat (10) @(negedge clk);
      check("ferr_count", n_err - e0, 1);
      check("ferr_data_held", int'(o_Data), 0);
      check("ferr_busy_after", int'(o_fBusy), 0);
      send_frame(8'h55, 1'b1, BIT_CLKS, -1, 1'b1);
      drain(200);
      check("recover_data", int'(o_Data), 8'h55);

      // Single-clock spike inside a data bit is outvoted.
      send_frame(8'hFF, 1'b1, BIT_CLKS, 4 * BIT_CLKS + 34, 1'b1);
      drain(200);
      check("spike_data", int'(o_Data), 8'hFF);

      // Reset in the middle of a frame aborts it silently.
      d0 = n_done;
      fork
         send_frame(8'hF0, 1'b1, BIT_CLKS, -1, 1'b0);
         begin
            repeat (5 * BIT_CLKS + 20) @(negedge clk);
            pulse_reset();
            check("midreset_data", int'(o_Data), 0);
            check("midreset_flags", int'({o_fDone, o_fErr, o_fBusy}), 0);
         end
      join
      repeat (100) @(negedge clk);
      check("midreset_no_done", n_done - d0, 0);
      send_frame(8'h81, 1'b1, BIT_CLKS, -1, 1'b1);
      drain(200);
      check("post_reset_data", int'(o_Data), 8'h81);

      // Random bytes, bit-rate skew, gaps and occasional bad stop bits.
      for (int i = 0; i < 40; i++) begin
         logic [7:0] b;
         logic       bad;
         b   = 8'($urandom);
         bad = ($urandom_range(0, 7) == 0);
         send_frame(b, !bad, int'($urandom_range(63, 65)), -1, 1'b1);
         if (bad) begin
            repeat ($urandom_range(0, 100)) @(negedge clk);
            rx = 1'b1;
            repeat ($urandom_range(4, 20)) @(negedge clk);
         end else begin
            repeat ($urandom_range(0, 12)) @(negedge clk);
         end
      end
      drain(1000);
      repeat (50) @(negedge clk);
      check("final_busy", int'(o_fBusy), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/uart_rx_oversample.md
Name: uart_rx_oversample

Overview:
- Oversampling UART receiver. It is the upstream stage that feeds the command/key/text byte stream into the DES control FSM.
- Recovers 8N1 frames from the asynchronous serial line. Each received byte is delivered as a one-cycle o_fDone strobe with o_Data.
- Adds what the DES front end needs for robust host links: input synchronisation, 16x majority-vote sampling, glitch rejection and framing-error reporting.

Parameters:
CLK_HZ, 50000000, system clock frequency in Hz
BAUD, 115200, serial bit rate
OVERSAMPLE, 16, sample ticks per bit (fixed at 16; other values unsupported)
DIV, CLK_HZ/(BAUD*OVERSAMPLE), clocks per sample tick (integer division, must be >= 2; default 27)

Ports:
i_Clk  input  1  system clock, all logic on rising edge
i_Rst  input  1  reset, synchronous, active-high
i_Rx  input  1  asynchronous serial line, idle high
o_Data  output  8  last correctly received byte, LSB received first; holds until next good frame
o_fDone  output  1  one-cycle pulse: o_Data valid and new
o_fErr  output  1  one-cycle pulse: stop bit sampled low (framing error)
o_fBusy  output  1  high from start-bit detection until frame end, including the error-recovery wait

Behaviour:
- Reset (i_Rst=1 at a clock edge): state IDLE; o_Data=0x00; o_fDone=0; o_fErr=0; o_fBusy=0; both synchroniser flops=1; tick counter=0; sample counter=0; bit counter=0.
- Synchroniser: i_Rx passes through 2 flops to give rx_s. All decisions use rx_s. Reset asserted mid-frame aborts the frame with no strobe.
- Tick generator: tick_cnt counts 0..DIV-1. tick=1 for one clock when tick_cnt==DIV-1. Cleared to 0 on start detection.
- Sample counter: samp counts 0..15, advancing on each tick. The wrap 15->0 marks the end of a bit period.
- Vote: at samp 7, 8 and 9, rx_s is captured. The bit value is the majority of the three captures (2 of 3).
- FSM:
  - IDLE: o_fBusy=0. If rx_s==0, go to START, clear tick_cnt/samp/bit counter, set o_fBusy=1.
  - START: at the end of the bit period, a vote of 0 goes to DATA; a vote of 1 goes to IDLE (glitch rejected, no strobe).
  - DATA: at the end of each bit period, the vote is shifted in LSB-first (shift right, vote into bit 7). After the 8th bit, go to STOP.
  - STOP: decision on the tick where samp==9, without waiting for the full stop bit. This gives early resynchronisation.
    - Vote 1: o_Data <= shift register; o_fDone=1 on the next clock for exactly one cycle; go to IDLE.
    - Vote 0: o_fErr=1 for one cycle; o_Data unchanged; go to BREAK.
  - BREAK: o_fBusy=1. Stay until rx_s==1, then go to IDLE. This prevents a held-low line or break from being parsed as back-to-back frames.
- o_fDone and o_fErr are never high together. Each is high for at most one cycle per frame.
- Back-to-back frames: a start edge arriving on rx_s any time after IDLE is re-entered, including the clock right after o_fDone, must be accepted.
- Latency: from the first rx_s low to o_fDone = 9 bit periods + 10 ticks + 1 clock, +/-1 clock. The end-to-end figure from i_Rx adds 2 clocks of synchroniser delay.
- Timing accuracy: sampling stays correct for a transmitter rate error up to +/-3%.

Test Plan:
1. DIV=4 (bit = 64 clocks): send 0xA5 as 8N1 -> exactly one o_fDone pulse with o_Data=0xA5; o_fErr stays 0; o_fBusy is low again after the pulse.
2. DIV=4: send the DES command/key sequence 0x02 0x01 0x23 0x45 0x67 0x89 0xAB 0xCD 0xEF back-to-back with no idle gap -> nine o_fDone pulses carrying those bytes in order, no o_fErr.
3. DIV=4: drive i_Rx low for 20 clocks (< 1/2 bit) then high -> no o_fDone, no o_fErr; o_fBusy returns to 0 one bit period after the glitch starts.
4. DIV=4: send 0x3C with the stop bit held low, line low for 200 more clocks, then high, then send 0x55 -> one o_fErr pulse; o_Data stays 0x00 until 0x55 is received; then o_fDone with o_Data=0x55.
5. DIV=4: mid-data of 0xFF, a single-clock low spike at samp 8 of bit 3 -> majority vote gives o_Data=0xFF.
6. DIV=4: assert i_Rst for 1 clock during bit 4 of a frame -> all outputs are 0 on the next clock; the remainder of the frame produces no o_fDone; the next clean frame 0x81 is received correctly.
